// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control unit: FSM states,
// opcode and ALU encodings, instruction field positions.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_EXEC_I = 4'd4,
    ST_ADDR   = 4'd5,
    ST_MEM_RD = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_WB_R   = 4'd8,
    ST_WB_I   = 4'd9,
    ST_WB_MEM = 4'd10,
    ST_BRANCH = 4'd11,
    ST_HALT   = 4'd12
  } state_e;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int RS_MSB    = 11;
  localparam int RS_LSB    = 9;
  localparam int RT_MSB    = 8;
  localparam int RT_LSB    = 6;
  localparam int RD_MSB    = 5;
  localparam int RD_LSB    = 3;
  localparam int FUNCT_MSB = 2;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 5;
  localparam int IMM_LSB   = 0;

  localparam int MEM_TIMEOUT_DEF = 15;

  // Retired-instruction counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore decode of the control FSM state (plus latched funct) into datapath
// strobes; only BRANCH additionally looks at the ALU zero flag.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [2:0] funct,
  input  logic       alu_zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       pc_src,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       mem_re,
  output logic       mem_we,
  output logic       alu_src_b,
  output logic [2:0] alu_op,
  output logic       busy
);

  // Per-state strobe table; everything defaults low.
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    pc_src     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    busy       = 1'b1;
    case (state_e'(state))
      ST_IDLE: busy = 1'b0;
      ST_FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
      end
      ST_DECODE: busy = 1'b1;
      ST_EXEC_R: alu_op = funct;
      ST_EXEC_I, ST_ADDR: alu_src_b = 1'b1;
      ST_MEM_RD: mem_re = 1'b1;
      ST_MEM_WR: mem_we = 1'b1;
      ST_WB_R: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      ST_WB_I: reg_we = 1'b1;
      ST_WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_BRANCH: begin
        alu_op = ALU_SUB;
        pc_we  = alu_zero;
        pc_src = alu_zero;
      end
      ST_HALT: busy = 1'b0;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control unit: state register, latched opcode/funct,
// memory wait counter, sticky status flags and retired-instruction count.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] im_data,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        pc_src,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        mem_re,
  output logic        mem_we,
  output logic        alu_src_b,
  output logic [2:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err,
  output logic [15:0] instr_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [2:0]          funct_q, funct_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;
  logic                retire_s;

  // Register fields are consumed by the datapath directly, not by control.
  logic unused_fields_s;
  assign unused_fields_s = ^im_data[RS_MSB:RD_LSB];

  // Next-state, field latching, wait counting and retirement.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    wait_d    = wait_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    retire_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        opcode_d = im_data[OPC_MSB:OPC_LSB];
        funct_d  = im_data[FUNCT_MSB:FUNCT_LSB];
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode_q)
          OP_R: begin
            if (funct_q > ALU_SLT) begin
              state_d   = ST_HALT;
              illegal_d = 1'b1;
            end else begin
              state_d = ST_EXEC_R;
            end
          end
          OP_ADDI:      state_d = ST_EXEC_I;
          OP_LW, OP_SW: state_d = ST_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_HALT: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
            retire_s = 1'b1;
          end
          default: begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_EXEC_R: state_d = ST_WB_R;
      ST_EXEC_I: state_d = ST_WB_I;
      ST_ADDR: begin
        wait_d = {WAIT_W{1'b0}};
        if (opcode_q == OP_LW) begin
          state_d = ST_MEM_RD;
        end else begin
          state_d = ST_MEM_WR;
        end
      end
      ST_MEM_RD, ST_MEM_WR: begin
        // A ready on the last permitted cycle still completes the access.
        if (mem_ready) begin
          wait_d = {WAIT_W{1'b0}};
          if (state_q == ST_MEM_RD) begin
            state_d = ST_WB_MEM;
          end else begin
            state_d  = ST_FETCH;
            retire_s = 1'b1;
          end
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d   = ST_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH: begin
        state_d  = ST_FETCH;
        retire_s = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (retire_s) begin
      cnt_d = sat_inc16(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control state and status registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      opcode_q  <= 4'h0;
      funct_q   <= 3'd0;
      wait_q    <= {WAIT_W{1'b0}};
      cnt_q     <= 16'd0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;
  assign instr_cnt = cnt_q;

  ctrl_decode u_decode (
    .state      (state_q),
    .funct      (funct_q),
    .alu_zero   (alu_zero),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .busy       (busy)
  );

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit that sequences the CPU datapath (PC, instruction register, 8×16-bit register file, ALU, data memory) through fetch/decode/execute/memory/writeback. It sits between instruction memory output and datapath control inputs, replacing single-cycle decode. It supports add, sub, and, or, slt, addi, lw, sw, beq, halt, with a ready handshake for multi-cycle data-memory access and a retired-instruction counter.

## Interface
- MEM_TIMEOUT, 15: max wait cycles in a memory state before bus error
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  level; sampled in IDLE to begin execution
- im_data  in  16  instruction word at current PC; opcode[15:12], rs[11:9], rt[8:6], rd[5:3], funct[2:0], imm[5:0]
- alu_zero  in  1  ALU zero flag (valid in BRANCH)
- mem_ready  in  1  data memory completed access this cycle
- pc_we, ir_we  out  1  PC / IR load enables
- pc_src  out  1  0 = PC+1, 1 = branch target
- reg_we  out  1  register-file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  writeback source = memory data
- mem_re, mem_we  out  1  data-memory read / write strobes
- alu_src_b  out  1  0 = reg B, 1 = sign-extended imm
- alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt
- busy  out  1  high in any state except IDLE and HALT
- halted, illegal, bus_err  out  1  sticky status
- instr_cnt  out  16  retired instructions, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, HALT.
- IDLE: all outputs 0; START=1 → FETCH.
- FETCH: ir_we=1, pc_we=1, pc_src=0; opcode and funct latched internally from im_data → DECODE.
- DECODE: no strobes. op 0 → EXEC_R; 1 (addi) → EXEC_I; 2 (lw) / 3 (sw) → ADDR; 4 (beq) → BRANCH; F (halt) → HALT with halted=1; any other → HALT with illegal=1. op 0 with funct>4 → HALT, illegal=1.
- EXEC_R: alu_op=funct, alu_src_b=0 → WB_R (reg_we=1, reg_dst=1).
- EXEC_I: alu_op=add, alu_src_b=1 → WB_I (reg_we=1, reg_dst=0).
- ADDR: alu_op=add, alu_src_b=1 → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD/MEM_WR: mem_re/mem_we held high until mem_ready=1 sampled; then MEM_RD → WB_MEM (reg_we=1, reg_dst=0, mem_to_reg=1), MEM_WR → FETCH. Wait counter resets on entry; when it reaches MEM_TIMEOUT without mem_ready → HALT, bus_err=1, instruction not retired.
- BRANCH: alu_op=sub, alu_src_b=0; if alu_zero, pc_we=1, pc_src=1 → FETCH.
- WB_* → FETCH. Instruction retires (instr_cnt+1, saturates at 0xFFFF) on WB_R, WB_I, WB_MEM, MEM_WR completion, BRANCH, and halt opcode entering HALT.
- HALT: absorbing; all strobes 0; only RST leaves. START ignored.
- START deassertion after leaving IDLE is ignored.

## Timing
- Outputs are Moore: decoded from state plus latched opcode/funct only, never directly from im_data.
- Cycles per instruction (mem_ready immediate): R/addi 4, sw 4, lw 5, beq 3, halt 2 to HALT. Each wait cycle adds 1.
- mem_ready is sampled only in MEM_RD/MEM_WR; ignored elsewhere.
- RST asserted at any time: state → IDLE, latched fields, wait counter, instr_cnt, status flags → 0, all outputs 0 immediately (asynchronously), including mid-MEM_WR.
- First FETCH occurs the cycle after START is sampled high in IDLE.

## Structure
- Package cpu_ctrl_pkg: state enum, opcode constants (OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT), alu_op encodings, instruction field positions.
- Sub-module ctrl_decode: combinational state+opcode+funct → control outputs; multicycle_ctrl holds state register, latches, wait counter, instr_cnt.

## Test plan
- RST then START=1, im_data=add r3,r1,r2 (0x0298), mem_ready=1 → FETCH, DECODE, EXEC_R (alu_op=0), WB_R (reg_we=1, reg_dst=1); instr_cnt=1 after 4 cycles.
- lw with mem_ready low 3 cycles → mem_re high 4 cycles, WB_MEM with mem_to_reg=1; total 8 cycles; instr_cnt increments once.
- beq with alu_zero=1 → BRANCH pc_we=1, pc_src=1; with alu_zero=0 → pc_we=0; both 3 cycles, both retire.
- Opcode 0x7 → HALT, illegal=1, busy=0, halted=0; START toggling causes no strobes.
- sw, mem_ready stuck 0, MEM_TIMEOUT=15 → mem_we high 15 cycles, then bus_err=1, HALT, instr_cnt unchanged.
- RST pulse mid-MEM_WR → mem_we drops without CLK edge; state IDLE, instr_cnt=0, all flags 0.
